// File: rtl/gf180mcu_ht_io_fix__pwr_seq.sv
// IO-ring power sequencer: enables supply segments in index order behind debounced
// power-good, shuts down in reverse order, and latches a fault on power-good loss or timeout.
module gf180mcu_ht_io_fix__pwr_seq #(
  parameter int unsigned NSEG     = 4,
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned DEB      = 3,
  parameter int unsigned TMO      = 255,
  localparam int unsigned IDX_W   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [NSEG-1:0]     pgood_i,
  input  logic [SETTLE_W-1:0] settle_i,
  output logic [NSEG-1:0]     seg_en_o,
  output logic                all_good_o,
  output logic                fault_o,
  output logic [IDX_W-1:0]    fault_seg_o,
  output logic [2:0]          state_o
);

  localparam int unsigned TMO_W = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam int unsigned DEB_W = $clog2(DEB + 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RAMP   = 3'd1,
    S_SETTLE = 3'd2,
    S_ON     = 3'd3,
    S_DOWN   = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NSEG-1:0]     seg_en_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic                all_good_q;
  logic                fault_q;
  logic [IDX_W-1:0]    fault_seg_q;

  logic [NSEG-1:0]     sync1_q;
  logic [NSEG-1:0]     sync2_q;
  logic [DEB_W-1:0]    deb_q [NSEG];
  logic [DEB_W-1:0]    deb_d [NSEG];
  logic [NSEG-1:0]     pg_ok;

  logic [NSEG-1:0]     fail_mask;
  logic                any_fail;
  logic [IDX_W-1:0]    fail_idx;
  logic [IDX_W-1:0]    top_idx;

  // Two-flop synchroniser for the asynchronous pad-ring power-good straps
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pgood_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: saturating run-length of synced-high cycles; a low cycle clears at once
  always_comb begin
    pg_ok = '0;
    for (int unsigned k = 0; k < NSEG; k++) begin
      deb_d[k] = deb_q[k];
      if (!sync2_q[k]) begin
        deb_d[k] = '0;
      end else if (deb_q[k] != DEB_W'(DEB)) begin
        deb_d[k] = deb_q[k] + DEB_W'(1);
      end
      pg_ok[k] = sync2_q[k] && (deb_q[k] == DEB_W'(DEB));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        deb_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        deb_q[k] <= deb_d[k];
      end
    end
  end

  // Lowest enabled segment that has lost power-good, and highest enabled segment
  always_comb begin
    fail_mask = seg_en_q & ~pg_ok;
    any_fail  = |fail_mask;
    fail_idx  = '0;
    for (int j = int'(NSEG) - 1; j >= 0; j--) begin
      if (fail_mask[j]) begin
        fail_idx = IDX_W'(j);
      end
    end
    top_idx = '0;
    for (int j = 0; j < int'(NSEG); j++) begin
      if (seg_en_q[j]) begin
        top_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_OFF;
      idx_q       <= '0;
      seg_en_q    <= '0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      all_good_q  <= 1'b0;
      fault_q     <= 1'b0;
      fault_seg_q <= '0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (en_i) begin
            idx_q    <= '0;
            seg_en_q <= NSEG'(1);
            tmo_q    <= '0;
            state_q  <= S_RAMP;
          end
        end

        S_RAMP: begin
          if (!en_i) begin
            cnt_q   <= '0;
            state_q <= S_DOWN;
          end else if (pg_ok[idx_q]) begin
            cnt_q   <= settle_i;
            state_q <= S_SETTLE;
          end else if (tmo_q == TMO_W'(TMO)) begin
            fault_q     <= 1'b1;
            fault_seg_q <= idx_q;
            seg_en_q    <= '0;
            state_q     <= S_FAULT;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_SETTLE: begin
          if (!en_i) begin
            cnt_q   <= '0;
            state_q <= S_DOWN;
          end else if (any_fail) begin
            fault_q     <= 1'b1;
            fault_seg_q <= fail_idx;
            seg_en_q    <= '0;
            state_q     <= S_FAULT;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - SETTLE_W'(1);
          end else if (idx_q == IDX_W'(NSEG - 1)) begin
            all_good_q <= 1'b1;
            state_q    <= S_ON;
          end else begin
            idx_q    <= idx_q + IDX_W'(1);
            seg_en_q <= seg_en_q | (NSEG'(2) << idx_q);
            tmo_q    <= '0;
            state_q  <= S_RAMP;
          end
        end

        // A power-good loss outranks a shutdown request here
        S_ON: begin
          if (any_fail) begin
            all_good_q  <= 1'b0;
            fault_q     <= 1'b1;
            fault_seg_q <= fail_idx;
            seg_en_q    <= '0;
            state_q     <= S_FAULT;
          end else if (!en_i) begin
            all_good_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_DOWN;
          end
        end

        // Peel off the highest segment, wait SETTLE, repeat; EN and power-good are ignored
        S_DOWN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - SETTLE_W'(1);
          end else if (|seg_en_q) begin
            seg_en_q <= seg_en_q & ~(NSEG'(1) << top_idx);
            cnt_q    <= settle_i;
          end else begin
            state_q <= S_OFF;
          end
        end

        S_FAULT: begin
          if (!en_i) begin
            fault_q <= 1'b0;
            state_q <= S_OFF;
          end
        end

        default: begin
          seg_en_q   <= '0;
          all_good_q <= 1'b0;
          state_q    <= S_OFF;
        end
      endcase
    end
  end

  assign seg_en_o    = seg_en_q;
  assign all_good_o  = all_good_q;
  assign fault_o     = fault_q;
  assign fault_seg_o = fault_seg_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_gf180mcu_ht_io_fix__pwr_seq.sv
// Bench for the IO-ring power sequencer: timed vector table plus hand sequences,
// expected outputs queued with a due cycle and compared when that cycle arrives.
module tb_gf180mcu_ht_io_fix__pwr_seq;

  localparam int unsigned NSEG = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] pg;
  logic [7:0] settle;
  logic [3:0] seg_en;
  logic       all_good;
  logic       fault;
  logic [1:0] fault_seg;
  logic [2:0] state;

  always #5 clk = ~clk;

  gf180mcu_ht_io_fix__pwr_seq #(
    .NSEG(NSEG), .SETTLE_W(8), .DEB(3), .TMO(255)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pgood_i(pg), .settle_i(settle),
    .seg_en_o(seg_en), .all_good_o(all_good), .fault_o(fault),
    .fault_seg_o(fault_seg), .state_o(state)
  );

  typedef struct {
    int         id;
    int         due;
    logic [3:0] seg;
    logic       ag;
    logic       f;
    logic [1:0] fs;
    logic [2:0] st;
  } exp_t;

  // Drive {en, pg}; expect outputs lat cycles later; then advance hold cycles
  typedef struct {
    logic       en;
    logic [3:0] pg;
    int         lat;
    int         hold;
    logic [3:0] seg;
    logic       ag;
    logic       f;
    logic [1:0] fs;
    logic [2:0] st;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void add(input logic e, input logic [3:0] p, input int lat, input int hold,
                              input logic [3:0] s, input logic a, input logic f,
                              input logic [1:0] fs, input logic [2:0] st);
    vec_t v;
    v.en = e; v.pg = p; v.lat = lat; v.hold = hold;
    v.seg = s; v.ag = a; v.f = f; v.fs = fs; v.st = st;
    vecs.push_back(v);
  endfunction

  function automatic void compare(input exp_t e);
    checks++;
    if (seg_en !== e.seg || all_good !== e.ag || fault !== e.f ||
        fault_seg !== e.fs || state !== e.st) begin
      failures++;
      $display("FAIL chk%0d cyc=%0d: got seg=%b ag=%b fault=%b fseg=%0d st=%0d, expected seg=%b ag=%b fault=%b fseg=%0d st=%0d",
               e.id, cyc, seg_en, all_good, fault, fault_seg, state, e.seg, e.ag, e.f, e.fs, e.st);
    end
  endfunction

  task automatic expect_at(input int id, input int lat, input logic [3:0] s, input logic a,
                           input logic f, input logic [1:0] fs, input logic [2:0] st);
    exp_t e;
    e.id = id; e.due = cyc + lat;
    e.seg = s; e.ag = a; e.f = f; e.fs = fs; e.st = st;
    sb.push_back(e);
  endtask

  task automatic check_now(input int id, input logic [3:0] s, input logic a, input logic f,
                           input logic [1:0] fs, input logic [2:0] st);
    exp_t e;
    e.id = id; e.due = cyc;
    e.seg = s; e.ag = a; e.f = f; e.fs = fs; e.st = st;
    compare(e);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pgk;
    logic [3:0] nxt;

    // Nominal power-up: each PGOOD rises 10 cycles after its enable
    add(1'b1, 4'b0000,  1,  0, 4'b0001, 1'b0, 1'b0, 2'd0, 3'd1);
    add(1'b1, 4'b0000, 11, 11, 4'b0001, 1'b0, 1'b0, 2'd0, 3'd1);
    for (int k = 0; k < 4; k++) begin
      pgk = 4'((1 << (k + 1)) - 1);
      nxt = (k < 3) ? 4'((1 << (k + 2)) - 1) : 4'b1111;
      add(1'b1, pgk,  5, 0, pgk, 1'b0, 1'b0, 2'd0, 3'd1);
      add(1'b1, pgk,  6, 0, pgk, 1'b0, 1'b0, 2'd0, 3'd2);
      add(1'b1, pgk, 10, 0, pgk, 1'b0, 1'b0, 2'd0, 3'd2);
      if (k < 3) add(1'b1, pgk, 11, 21, nxt, 1'b0, 1'b0, 2'd0, 3'd1);
      else       add(1'b1, pgk, 11, 21, nxt, 1'b1, 1'b0, 2'd0, 3'd3);
    end
    // Orderly shutdown, PGOOD[3:2] dropped mid-sequence, EN re-raised late
    add(1'b0, 4'b1111,  1,  0, 4'b1111, 1'b0, 1'b0, 2'd0, 3'd4);
    add(1'b0, 4'b1111,  2,  3, 4'b0111, 1'b0, 1'b0, 2'd0, 3'd4);
    add(1'b0, 4'b0011,  3,  0, 4'b0111, 1'b0, 1'b0, 2'd0, 3'd4);
    add(1'b0, 4'b0011,  4,  0, 4'b0011, 1'b0, 1'b0, 2'd0, 3'd4);
    add(1'b0, 4'b0011,  9,  0, 4'b0001, 1'b0, 1'b0, 2'd0, 3'd4);
    add(1'b0, 4'b0011, 14, 16, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd4);
    add(1'b1, 4'b0011,  2,  0, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd4);
    add(1'b1, 4'b0011,  3,  0, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
    add(1'b1, 4'b0011,  4,  4, 4'b0001, 1'b0, 1'b0, 2'd0, 3'd1);
    // Timeout on segment 2 (PGOOD[2] stays low)
    add(1'b1, 4'b0011,  12,   0, 4'b0111, 1'b0, 1'b0, 2'd0, 3'd1);
    add(1'b1, 4'b0011, 267,   0, 4'b0111, 1'b0, 1'b0, 2'd0, 3'd1);
    add(1'b1, 4'b0011, 268, 273, 4'b0000, 1'b0, 1'b1, 2'd2, 3'd5);
    add(1'b1, 4'b0011,   1,   1, 4'b0000, 1'b0, 1'b1, 2'd2, 3'd5);
    add(1'b0, 4'b0011,   1,   2, 4'b0000, 1'b0, 1'b0, 2'd2, 3'd0);

    rst_n = 1'b1; en = 1'b0; pg = 4'b0000; settle = 8'd4;
    fork
      forever begin
        @(negedge clk);
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].due <= cyc) begin
            compare(sb[i]);
            sb.delete(i);
          end
        end
      end
    join_none

    #1 rst_n = 1'b0;
    #2 check_now(1, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    expect_at(2, 2, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
    adv(3);

    foreach (vecs[r]) begin
      en = vecs[r].en;
      pg = vecs[r].pg;
      expect_at(100 + r, vecs[r].lat, vecs[r].seg, vecs[r].ag, vecs[r].f, vecs[r].fs, vecs[r].st);
      if (vecs[r].hold > 0) adv(vecs[r].hold);
    end

    // Brown-out in ON: PGOOD[1] and PGOOD[3] drop together, lowest index reported
    pg = 4'b1111; en = 1'b1;
    expect_at(300, 25, 4'b1111, 1'b1, 1'b0, 2'd2, 3'd3);
    adv(30);
    pg = 4'b0101;
    expect_at(301, 2, 4'b1111, 1'b1, 1'b0, 2'd2, 3'd3);
    expect_at(302, 3, 4'b0000, 1'b0, 1'b1, 2'd1, 3'd5);
    adv(5);
    en = 1'b0;
    expect_at(303, 1, 4'b0000, 1'b0, 1'b0, 2'd1, 3'd0);
    adv(1);
    pg = 4'b0000;
    adv(3);

    // Glitch rejection: a 2-cycle PGOOD[0] pulse must not complete the debounce
    en = 1'b1;
    expect_at(400, 1, 4'b0001, 1'b0, 1'b0, 2'd1, 3'd1);
    adv(3);
    pg = 4'b0001;
    adv(2);
    pg = 4'b0000;
    expect_at(401, 7, 4'b0001, 1'b0, 1'b0, 2'd1, 3'd1);
    adv(10);
    pg = 4'b0001;
    expect_at(402, 5, 4'b0001, 1'b0, 1'b0, 2'd1, 3'd1);
    expect_at(403, 6, 4'b0001, 1'b0, 1'b0, 2'd1, 3'd2);
    expect_at(404, 11, 4'b0011, 1'b0, 1'b0, 2'd1, 3'd1);
    adv(11);
    pg = 4'b0011;
    expect_at(405, 6, 4'b0011, 1'b0, 1'b0, 2'd1, 3'd2);
    adv(8);

    // Asynchronous reset mid-SETTLE, between clock edges
    #1 rst_n = 1'b0;
    #1 check_now(500, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
    en = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    expect_at(501, 1, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
    expect_at(502, 4, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0);
    adv(6);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending: %0d expected results never compared, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf180mcu_ht_io_fix__pwr_seq.md
Name: gf180mcu_ht_io_fix__pwr_seq

Overview:
- Parametrised power-sequencing controller for the IO ring.
- Brings up NSEG IO supply segments one at a time, in index order. These are the segments bounded by the DVDD/DVSS supply pads.
- Each segment must show a debounced power-good before the next one is enabled. Shutdown runs in reverse order.
- Any power-good loss or timeout latches a fault and drops all segments.
- Sits between the chip power-management logic and the pad-ring enable/power-good straps.

Parameters:
- NSEG, 4, number of supply segments (1..16).
- SETTLE_W, 8, width of the SETTLE delay input.
- DEB, 3, consecutive synchronised-high cycles needed to declare a segment good (≥1).
- TMO, 255, maximum cycles in RAMP waiting for power-good before FAULT (≥1).

Ports:
- CLK  input  1  sequencer clock.
- RSTN  input  1  asynchronous active-low reset.
- EN  input  1  power-up request; level-sensitive, synchronous to CLK.
- PGOOD  input  NSEG  per-segment power-good from pad ring; asynchronous.
- SETTLE  input  SETTLE_W  settle delay in cycles, applied after each power-good and between shutdown steps; sampled when each count loads.
- SEG_EN  output  NSEG  per-segment supply enable, registered.
- ALL_GOOD  output  1  high only in ON.
- FAULT  output  1  high in FAULT state.
- FAULT_SEG  output  clog2(NSEG) (min 1)  segment index that caused the last fault.
- STATE  output  3  encoding: OFF=0, RAMP=1, SETTLE=2, ON=3, DOWN=4, FAULT=5.

Behaviour:
- Reset (asynchronous): state OFF; SEG_EN=0, ALL_GOOD=0, FAULT=0, FAULT_SEG=0, STATE=0; idx=0; all counters and synchronisers cleared.
- Power-good path:
  - Each PGOOD bit passes through a 2-flop synchroniser, then a debounce counter.
  - pg_ok[k] sets after DEB consecutive synced-high cycles and clears on the first synced-low cycle.
  - Worst-case latency from PGOOD rise to pg_ok: 2+DEB cycles.
- OFF:
  - EN=1 at an edge: idx←0, SEG_EN[0]←1, tmo_cnt←0, go to RAMP. SEG_EN[0] is visible one cycle after EN is sampled.
- RAMP, priority in this order:
  1. EN=0 → DOWN.
  2. pg_ok[idx] → SETTLE, cnt←SETTLE.
  3. tmo_cnt==TMO → FAULT, FAULT_SEG←idx.
  4. Otherwise tmo_cnt++.
- SETTLE, priority in this order:
  1. EN=0 → DOWN.
  2. Any pg_ok[j]=0 for an enabled segment j → FAULT, FAULT_SEG←lowest such j.
  3. cnt≠0 → cnt--.
  4. cnt==0 and idx==NSEG-1 → ON.
  5. cnt==0 otherwise → idx++, SEG_EN[idx+1]←1, tmo_cnt←0, RAMP.
  - SETTLE=0 means exactly one cycle in SETTLE.
- ON:
  - ALL_GOOD=1.
  - Any pg_ok drop → FAULT (lowest index). This has priority over EN=0.
  - EN=0 → DOWN, ALL_GOOD←0.
- DOWN:
  - Clear the highest set SEG_EN bit, load cnt←SETTLE, count to 0, repeat.
  - When SEG_EN==0 and cnt==0 → OFF. A lone clear of the last segment still waits SETTLE.
  - EN reasserting during DOWN is ignored until OFF is reached.
  - pg_ok drops during DOWN are not faults.
- FAULT:
  - SEG_EN←0 on entry (same edge as the state change); FAULT=1.
  - Held until EN=0 is sampled, then → OFF, FAULT←0.
  - FAULT_SEG holds its value until the next fault.
- Simultaneous pg_ok drops: lowest index wins.
- Counter widths:
  - tmo_cnt width is clog2(TMO+1).
  - cnt width is SETTLE_W; it never wraps, and decrement stops at 0.
- NSEG=1: idx is constant 0; the sequence is RAMP→SETTLE→ON.
- Reset mid-sequence: all SEG_EN drop asynchronously; no reverse-order shutdown.

Test Plan (NSEG=4, DEB=3, TMO=255, SETTLE=4):
- Nominal power-up:
  - Stimulus: EN=1; each PGOOD[k] rises 10 cycles after SEG_EN[k].
  - Response: SEG_EN steps 0001→0011→0111→1111; each step is 10+2+3+SETTLE-path cycles apart. ALL_GOOD=1 after the last SETTLE; STATE=3.
- Timeout:
  - Stimulus: EN=1; PGOOD[2] never rises.
  - Response: 256 cycles after reaching RAMP for idx 2, FAULT=1, FAULT_SEG=2, SEG_EN=0000, STATE=5. EN=0 → STATE=0, FAULT=0.
- Brown-out in ON:
  - Stimulus: PGOOD[1] and PGOOD[3] drop on the same cycle.
  - Response: 2+1 cycles later FAULT=1, FAULT_SEG=1, ALL_GOOD=0, SEG_EN=0000.
- Orderly shutdown:
  - Stimulus: from ON, EN=0.
  - Response: SEG_EN 1111→0111→0011→0001→0000, with each step 5 cycles apart; then STATE=0. A PGOOD drop during this sequence causes no fault.
- Glitch rejection:
  - Stimulus: PGOOD[0] pulses high for 2 cycles during RAMP.
  - Response: no transition to SETTLE. A later stable high advances normally.
- Async reset:
  - Stimulus: assert RSTN=0 mid-SETTLE with SEG_EN=0011.
  - Response: all outputs 0 immediately, without waiting for a clock edge; after release, STATE=0.
